// File: rtl/systolic_tile_scheduler.sv
// Output-tile sequencer for an output-stationary systolic array: walks C tiles row-major,
// streams A/B operand reads, lets the wavefront drain, then writes the tile rows out.
module systolic_tile_scheduler #(
    parameter int PE_ARRAY_NUM_ROWS      = 32,
    parameter int PE_ARRAY_NUM_ROWS_LOG2 = 5,
    parameter int PE_ARRAY_NUM_COLS      = 32,
    parameter int PE_ARRAY_NUM_COLS_LOG2 = 5,
    parameter int MAX_M_SIZE_LOG2        = 9,
    parameter int MAX_K_SIZE_LOG2        = 9,
    parameter int MAX_N_SIZE_LOG2        = 9,
    parameter int OPND1_SRAM_AWIDTH      = 10,
    parameter int OPND2_SRAM_AWIDTH      = 10,
    parameter int OUT_SRAM_AWIDTH        = 10
) (
    input  logic                              CLK,
    input  logic                              RSTn,
    input  logic                              START,
    input  logic                              STALL,
    input  logic [MAX_M_SIZE_LOG2-1:0]        M_SIZE_in,
    input  logic [MAX_K_SIZE_LOG2-1:0]        K_SIZE_in,
    input  logic [MAX_N_SIZE_LOG2-1:0]        N_SIZE_in,
    output logic                              OPND1_RE_out,
    output logic [OPND1_SRAM_AWIDTH-1:0]      OPND1_ADDR_out,
    output logic                              OPND2_RE_out,
    output logic [OPND2_SRAM_AWIDTH-1:0]      OPND2_ADDR_out,
    output logic                              PE_FEED_VALID_out,
    output logic                              PE_ACC_CLR_out,
    output logic                              OUT_WE_out,
    output logic [OUT_SRAM_AWIDTH-1:0]        OUT_ADDR_out,
    output logic [PE_ARRAY_NUM_ROWS_LOG2-1:0] OUT_ROW_SEL_out,
    output logic [PE_ARRAY_NUM_COLS_LOG2:0]   TILE_COLS_out,
    output logic                              BUSY_out,
    output logic                              IS_FINISHED_out
);

    localparam int MW        = MAX_M_SIZE_LOG2;
    localparam int KW        = MAX_K_SIZE_LOG2;
    localparam int NW        = MAX_N_SIZE_LOG2;
    localparam int RL        = PE_ARRAY_NUM_ROWS_LOG2;
    localparam int CL        = PE_ARRAY_NUM_COLS_LOG2;
    localparam int A1W       = OPND1_SRAM_AWIDTH;
    localparam int A2W       = OPND2_SRAM_AWIDTH;
    localparam int OW        = OUT_SRAM_AWIDTH;
    localparam int DRAIN_CYC = PE_ARRAY_NUM_ROWS + PE_ARRAY_NUM_COLS - 1;
    localparam int DW        = $clog2(DRAIN_CYC + 1);

    localparam logic [MW-1:0] M_ONE = {{(MW-1){1'b0}}, 1'b1};
    localparam logic [KW-1:0] K_ONE = {{(KW-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0] N_ONE = {{(NW-1){1'b0}}, 1'b1};
    localparam logic [RL:0]   R_ONE = {{RL{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic          armed;
    logic [MW-1:0] m_size, mt, mt_tiles;
    logic [KW-1:0] k_size, k_cnt;
    logic [NW-1:0] n_size, nt, nt_tiles;
    logic [DW-1:0] drain_cnt;
    logic [RL-1:0] r_cnt;
    logic          feed_valid;
    logic          acc_clr_pipe;

    logic [MW:0]   m_round;
    logic [NW:0]   n_round;
    logic [MW-1:0] m_rem;
    logic [NW-1:0] n_rem;
    logic [RL:0]   valid_rows;
    logic [CL:0]   valid_cols;
    logic          start_ok, size_zero;
    logic          feed_last, drain_last, write_last;
    logic          tile_wrap, last_tile, in_tile;

    // Edge tiles only cover what is left of M or N; interior tiles are full array size.
    function automatic logic [RL:0] clamp_rows(input logic [MW-1:0] rem);
        if (rem >= MW'(PE_ARRAY_NUM_ROWS))
            return (RL+1)'(PE_ARRAY_NUM_ROWS);
        return (RL+1)'(rem);
    endfunction

    function automatic logic [CL:0] clamp_cols(input logic [NW-1:0] rem);
        if (rem >= NW'(PE_ARRAY_NUM_COLS))
            return (CL+1)'(PE_ARRAY_NUM_COLS);
        return (CL+1)'(rem);
    endfunction

    assign m_round    = {1'b0, m_size} + (MW+1)'(PE_ARRAY_NUM_ROWS - 1);
    assign n_round    = {1'b0, n_size} + (NW+1)'(PE_ARRAY_NUM_COLS - 1);
    assign m_rem      = m_size - (mt << RL);
    assign n_rem      = n_size - (nt << CL);
    assign valid_rows = clamp_rows(m_rem);
    assign valid_cols = clamp_cols(n_rem);

    assign start_ok   = START && armed;
    assign size_zero  = (m_size == '0) || (k_size == '0) || (n_size == '0);
    assign feed_last  = (k_cnt == k_size - K_ONE);
    assign drain_last = (drain_cnt == DW'(DRAIN_CYC - 1));
    assign write_last = ({1'b0, r_cnt} == valid_rows - R_ONE);
    assign tile_wrap  = (nt == nt_tiles - N_ONE);
    assign last_tile  = tile_wrap && (mt == mt_tiles - M_ONE);
    assign in_tile    = (state == S_FEED) || (state == S_DRAIN) || (state == S_WRITE);

    always_ff @(posedge CLK) begin
        if (!RSTn)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_ok) state_next = S_LOAD;
            S_LOAD:  state_next = size_zero ? S_DONE : S_FEED;
            S_FEED:  if (feed_last) state_next = S_DRAIN;
            S_DRAIN: if (drain_last) state_next = S_WRITE;
            S_WRITE: if (write_last) state_next = S_NEXT;
            S_NEXT:  state_next = last_tile ? S_DONE : S_FEED;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (STALL)
            state_next = state;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            armed        <= 1'b1;
            m_size       <= '0;
            k_size       <= '0;
            n_size       <= '0;
            mt           <= '0;
            nt           <= '0;
            mt_tiles     <= '0;
            nt_tiles     <= '0;
            k_cnt        <= '0;
            drain_cnt    <= '0;
            r_cnt        <= '0;
            feed_valid   <= 1'b0;
            acc_clr_pipe <= 1'b0;
        end else begin
            // A held-high START must see a low cycle before it can launch another job.
            if (!START)
                armed <= 1'b1;
            else if (state == S_IDLE && !STALL)
                armed <= 1'b0;

            if (!STALL) begin
                feed_valid   <= (state == S_FEED);
                acc_clr_pipe <= (state == S_FEED) && (k_cnt == '0);

                case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            m_size <= M_SIZE_in;
                            k_size <= K_SIZE_in;
                            n_size <= N_SIZE_in;
                        end
                    end
                    S_LOAD: begin
                        mt_tiles  <= MW'(m_round >> RL);
                        nt_tiles  <= NW'(n_round >> CL);
                        mt        <= '0;
                        nt        <= '0;
                        k_cnt     <= '0;
                        drain_cnt <= '0;
                        r_cnt     <= '0;
                    end
                    S_FEED:  k_cnt <= feed_last ? '0 : k_cnt + K_ONE;
                    S_DRAIN: drain_cnt <= drain_last ? '0 : drain_cnt + DW'(1);
                    S_WRITE: r_cnt <= write_last ? '0 : r_cnt + RL'(1);
                    S_NEXT: begin
                        if (tile_wrap) begin
                            nt <= '0;
                            mt <= mt + M_ONE;
                        end else begin
                            nt <= nt + N_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Addresses wrap modulo the SRAM depth; doing the math at the address width gives the same result.
    assign OPND1_ADDR_out = A1W'(mt) * A1W'(k_size) + A1W'(k_cnt);
    assign OPND2_ADDR_out = A2W'(nt) * A2W'(k_size) + A2W'(k_cnt);
    assign OUT_ADDR_out   = (OW'(mt) * OW'(nt_tiles) + OW'(nt)) * OW'(PE_ARRAY_NUM_ROWS)
                            + OW'(r_cnt);

    assign OPND1_RE_out      = (state == S_FEED) && !STALL;
    assign OPND2_RE_out      = (state == S_FEED) && !STALL;
    assign PE_FEED_VALID_out = feed_valid;
    assign PE_ACC_CLR_out    = acc_clr_pipe && !STALL;
    assign OUT_WE_out        = (state == S_WRITE) && !STALL;
    assign OUT_ROW_SEL_out   = r_cnt;
    assign TILE_COLS_out     = in_tile ? valid_cols : '0;
    assign BUSY_out          = (state != S_IDLE);
    assign IS_FINISHED_out   = (state == S_DONE) && !STALL;

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Scoreboard bench for systolic_tile_scheduler: expected reads, writes, clears and
// finish cycles are queued per job and a negedge monitor checks them as the DUT emits them.
module tb_systolic_tile_scheduler;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       START = 1'b0;
    logic       STALL = 1'b0;
    logic [8:0] M_SIZE_in = '0;
    logic [8:0] K_SIZE_in = '0;
    logic [8:0] N_SIZE_in = '0;
    logic       OPND1_RE_out, OPND2_RE_out, PE_FEED_VALID_out, PE_ACC_CLR_out;
    logic       OUT_WE_out, BUSY_out, IS_FINISHED_out;
    logic [9:0] OPND1_ADDR_out, OPND2_ADDR_out, OUT_ADDR_out;
    logic [4:0] OUT_ROW_SEL_out;
    logic [5:0] TILE_COLS_out;

    systolic_tile_scheduler dut (
        .CLK(CLK), .RSTn(RSTn), .START(START), .STALL(STALL),
        .M_SIZE_in(M_SIZE_in), .K_SIZE_in(K_SIZE_in), .N_SIZE_in(N_SIZE_in),
        .OPND1_RE_out(OPND1_RE_out), .OPND1_ADDR_out(OPND1_ADDR_out),
        .OPND2_RE_out(OPND2_RE_out), .OPND2_ADDR_out(OPND2_ADDR_out),
        .PE_FEED_VALID_out(PE_FEED_VALID_out), .PE_ACC_CLR_out(PE_ACC_CLR_out),
        .OUT_WE_out(OUT_WE_out), .OUT_ADDR_out(OUT_ADDR_out),
        .OUT_ROW_SEL_out(OUT_ROW_SEL_out), .TILE_COLS_out(TILE_COLS_out),
        .BUSY_out(BUSY_out), .IS_FINISHED_out(IS_FINISHED_out)
    );

    always #5 CLK = ~CLK;

    typedef struct { int a1; int a2; } rd_t;
    typedef struct { int addr; int row; int tc; } wr_t;

    rd_t rd_q[$];
    wr_t wr_q[$];
    int  clr_q[$];
    int  fin_q[$];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   fv_count = 0;
    logic busy_q = 1'b0;
    logic stall_q = 1'b0;
    int   a1_q = 0, a2_q = 0, oa_q = 0;
    rd_t  mon_rd;
    wr_t  mon_wr;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected traffic for one job: row-major tiles, full K reads per tile.
    task automatic expect_job(input int m, input int k, input int n, input int fin);
        int mtn, ntn, t0, vr, tc;
        rd_t r;
        wr_t w;
        fin_q.push_back(fin);
        if (m == 0 || k == 0 || n == 0) return;
        mtn = (m + 31) / 32;
        ntn = (n + 31) / 32;
        t0 = 2;
        for (int mt = 0; mt < mtn; mt++) begin
            for (int nt = 0; nt < ntn; nt++) begin
                vr = (m - mt * 32 > 32) ? 32 : m - mt * 32;
                tc = (n - nt * 32 > 32) ? 32 : n - nt * 32;
                for (int kk = 0; kk < k; kk++) begin
                    r.a1 = (mt * k + kk) & 1023;
                    r.a2 = (nt * k + kk) & 1023;
                    rd_q.push_back(r);
                end
                clr_q.push_back(t0 + 1);
                for (int rr = 0; rr < vr; rr++) begin
                    w.addr = ((mt * ntn + nt) * 32 + rr) & 1023;
                    w.row  = rr;
                    w.tc   = tc;
                    wr_q.push_back(w);
                end
                t0 = t0 + k + 63 + vr + 1;
            end
        end
    endtask

    always @(negedge CLK) begin
        if (BUSY_out && !busy_q) cyc = 1;
        else if (BUSY_out) cyc = cyc + 1;
        busy_q = BUSY_out;
        if (PE_FEED_VALID_out) fv_count++;

        if (OPND1_RE_out || OPND2_RE_out) begin
            check("re_pair", int'(OPND1_RE_out), int'(OPND2_RE_out));
            if (rd_q.size() == 0) check("unexpected_rd", 1, 0);
            else begin
                mon_rd = rd_q.pop_front();
                check("opnd1_addr", int'(OPND1_ADDR_out), mon_rd.a1);
                check("opnd2_addr", int'(OPND2_ADDR_out), mon_rd.a2);
            end
        end
        if (OUT_WE_out) begin
            if (wr_q.size() == 0) check("unexpected_we", 1, 0);
            else begin
                mon_wr = wr_q.pop_front();
                check("out_addr", int'(OUT_ADDR_out), mon_wr.addr);
                check("out_row_sel", int'(OUT_ROW_SEL_out), mon_wr.row);
                check("tile_cols", int'(TILE_COLS_out), mon_wr.tc);
            end
        end
        if (PE_ACC_CLR_out) begin
            check("clr_with_valid", int'(PE_FEED_VALID_out), 1);
            if (clr_q.size() == 0) check("unexpected_clr", 1, 0);
            else check("acc_clr_cycle", cyc, clr_q.pop_front());
        end
        if (IS_FINISHED_out) begin
            if (fin_q.size() == 0) check("unexpected_finish", 1, 0);
            else check("finish_cycle", cyc, fin_q.pop_front());
        end
        if (STALL && RSTn) begin
            check("stall_re", int'(OPND1_RE_out), 0);
            check("stall_we", int'(OUT_WE_out), 0);
            if (stall_q) begin
                check("stall_opnd1_hold", int'(OPND1_ADDR_out), a1_q);
                check("stall_opnd2_hold", int'(OPND2_ADDR_out), a2_q);
                check("stall_out_hold", int'(OUT_ADDR_out), oa_q);
            end
        end
        stall_q = STALL;
        a1_q = int'(OPND1_ADDR_out);
        a2_q = int'(OPND2_ADDR_out);
        oa_q = int'(OUT_ADDR_out);
    end

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, int'(BUSY_out), 0);
        check({tag, "_strobes"}, int'({OPND1_RE_out, OPND2_RE_out, PE_FEED_VALID_out,
                                       PE_ACC_CLR_out, OUT_WE_out, IS_FINISHED_out}), 0);
        check({tag, "_addrs"}, int'(OPND1_ADDR_out | OPND2_ADDR_out | OUT_ADDR_out), 0);
        check({tag, "_sel_cols"}, int'(OUT_ROW_SEL_out) + int'(TILE_COLS_out), 0);
    endtask

    task automatic start_job(input int m, input int k, input int n);
        @(posedge CLK); #1;
        M_SIZE_in = 9'(m);
        K_SIZE_in = 9'(k);
        N_SIZE_in = 9'(n);
        START = 1'b1;
    endtask

    task automatic wait_finish(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (IS_FINISHED_out) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic end_job(input string name, input int exp_fv);
        @(negedge CLK);
        check({name, "_rd_left"}, rd_q.size(), 0);
        check({name, "_wr_left"}, wr_q.size(), 0);
        check({name, "_clr_left"}, clr_q.size(), 0);
        check({name, "_fin_left"}, fin_q.size(), 0);
        check({name, "_feed_valid_cycles"}, fv_count, exp_fv);
        fv_count = 0;
        rd_q.delete(); wr_q.delete(); clr_q.delete(); fin_q.delete();
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (2) @(posedge CLK);
    endtask

    task automatic run_plain(input string name, input int m, input int k, input int n,
                             input int fin, input int exp_fv);
        expect_job(m, k, n, fin);
        start_job(m, k, n);
        wait_finish(name, fin + 50);
        end_job(name, exp_fv);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1 RSTn = 1'b1;
        @(negedge CLK);
        check_quiet("reset");

        // Single tile with START held high well past completion.
        expect_job(32, 32, 32, 130);
        start_job(32, 32, 32);
        wait_finish("one_tile", 200);
        repeat (20) @(negedge CLK);
        check("held_start_no_rerun", int'(BUSY_out), 0);
        end_job("one_tile", 32);

        run_plain("sq128", 128, 128, 128, 3586, 2048);
        run_plain("m40", 40, 8, 32, 186, 16);
        run_plain("n40", 32, 4, 40, 202, 8);

        // Five stall cycles inside FEED and five inside WRITE.
        expect_job(32, 32, 32, 140);
        start_job(32, 32, 32);
        repeat (9) @(posedge CLK);
        #1 STALL = 1'b1;
        repeat (5) @(posedge CLK);
        #1 STALL = 1'b0;
        repeat (96) @(posedge CLK);
        #1 STALL = 1'b1;
        check("stall_in_write", int'(dut.state == 3'd4), 1);
        repeat (5) @(posedge CLK);
        #1 STALL = 1'b0;
        wait_finish("stall", 200);
        end_job("stall", 37);

        run_plain("k0", 32, 0, 32, 2, 0);

        // Reset in the middle of DRAIN, then a clean restart.
        expect_job(32, 32, 32, 130);
        start_job(32, 32, 32);
        repeat (50) @(posedge CLK);
        #1;
        RSTn = 1'b0;
        START = 1'b0;
        @(posedge CLK); #1;
        RSTn = 1'b1;
        @(negedge CLK);
        check_quiet("mid_reset");
        rd_q.delete(); wr_q.delete(); clr_q.delete(); fin_q.delete();
        fv_count = 0;
        repeat (3) @(negedge CLK);
        check("post_reset_idle", int'(BUSY_out), 0);
        run_plain("restart", 32, 32, 32, 130, 32);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
